// File: rtl/alu_sub_comp.sv
// ============================================================================
// alu_sub_comp
// ----------------------------------------------------------------------------
// Registered unsigned subtractor with borrow-in/borrow-out and a separate
// unsigned greater-than comparator. A new operation is accepted on every
// rising clock edge. All three results appear together one cycle later.
//
// The difference and borrow come from a ripple-borrow chain of full-subtractor
// cells. The comparator is an independent MSB-first magnitude chain and does
// not share logic with the subtractor.
//
// Parameters
//   BITS        operand / result width, legal range 2..64
//
// Ports
//   i_clk       clock; all state changes on the rising edge
//   i_rst       asynchronous active-high reset; clears every output
//   i_a         minuend (unsigned)
//   i_b         subtrahend (unsigned)
//   i_carry     borrow-in; 1 subtracts one extra
//   o_out_sub   registered difference, (a - b - carry) mod 2^BITS
//   o_carry     registered borrow-out, 1 when a < b + carry
//   o_out_comp  registered flag, 1 when a > b (borrow-in ignored)
// ============================================================================
module alu_sub_comp #(
    parameter int BITS = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    input  logic            i_carry,
    output logic [BITS-1:0] o_out_sub,
    output logic            o_carry,
    output logic            o_out_comp
);

    // ------------------------------------------------------------------------
    // Ripple-borrow subtractor
    // borrow[0] is the borrow-in. borrow[i+1] is the borrow out of bit i.
    // ------------------------------------------------------------------------
    logic [BITS:0]   borrow;
    logic [BITS-1:0] diff;

    assign borrow[0] = i_carry;

    for (genvar i = 0; i < BITS; i++) begin : g_sub_cell
        // Full-subtractor cell. A borrow is generated when a=0 and b=1. An
        // incoming borrow passes through when a and b are equal.
        assign diff[i]       = i_a[i] ^ i_b[i] ^ borrow[i];
        assign borrow[i + 1] = (~i_a[i] & i_b[i])
                             | (~(i_a[i] ^ i_b[i]) & borrow[i]);
    end

    // ------------------------------------------------------------------------
    // MSB-first magnitude comparator
    // eq_above[i] : every bit above position i is equal in a and b.
    // gt_from[i]  : looking at bits BITS-1 down to i, a is already greater.
    // The first differing bit, counting from the MSB, decides the result.
    // Lower bits cannot change that decision.
    // ------------------------------------------------------------------------
    logic [BITS:1] eq_above;
    logic [BITS:0] gt_from;

    assign eq_above[BITS] = 1'b1;
    assign gt_from[BITS]  = 1'b0;

    for (genvar i = BITS - 1; i >= 0; i--) begin : g_cmp_cell
        assign gt_from[i] = gt_from[i + 1]
                          | (eq_above[i + 1] & i_a[i] & ~i_b[i]);
        if (i > 0) begin : g_eq
            assign eq_above[i] = eq_above[i + 1] & ~(i_a[i] ^ i_b[i]);
        end
    end

    // ------------------------------------------------------------------------
    // Output registers
    // Every output comes straight from a flop, so there is no combinational
    // path from the inputs to the outputs. Reset is asynchronous. A reset
    // asserted between edges therefore discards a result that is still in
    // flight.
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. All three flops
    // then sample the values from before the edge, with no ordering race.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_out_sub  <= '0;
            o_carry    <= 1'b0;
            o_out_comp <= 1'b0;
        end else begin
            o_out_sub  <= diff;
            o_carry    <= borrow[BITS];
            o_out_comp <= gt_from[0];
        end
    end

endmodule

// File: tb/tb_alu_sub_comp.sv
// ============================================================================
// tb_alu_sub_comp
// ----------------------------------------------------------------------------
// Self-checking bench for alu_sub_comp. It uses an 8-bit and a 16-bit
// instance. Expected values are either fixed constants or come from a plain
// arithmetic model of subtraction and comparison.
// ============================================================================
module tb_alu_sub_comp;

    logic clk;
    logic clk_en;
    logic rst;

    logic [7:0]  a8, b8, sub8;
    logic        c8, co8, cmp8;
    logic [15:0] a16, b16, sub16;
    logic        c16, co16, cmp16;

    int checks;
    int errors;

    alu_sub_comp #(.BITS(8)) dut8 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_a        (a8),
        .i_b        (b8),
        .i_carry    (c8),
        .o_out_sub  (sub8),
        .o_carry    (co8),
        .o_out_comp (cmp8)
    );

    alu_sub_comp #(.BITS(16)) dut16 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_a        (a16),
        .i_b        (b16),
        .i_carry    (c16),
        .o_out_sub  (sub16),
        .o_carry    (co16),
        .o_out_comp (cmp16)
    );

    // Clock is gated so the reset test can run with no edges at all.
    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    // Arithmetic reference: exact integer subtraction and comparison.
    function automatic void model(input int bits, input longint unsigned a,
                                  input longint unsigned b, input bit c,
                                  output longint unsigned diff,
                                  output bit borrow, output bit gt);
        longint unsigned mask;
        mask   = (64'd1 << bits) - 64'd1;
        diff   = (a - b - 64'(c)) & mask;
        borrow = (a < b + 64'(c));
        gt     = (a > b);
    endfunction

    // Drives one 8-bit operation and samples it 1 time unit after the edge.
    task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic c);
        a8 = a; b8 = b; c8 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clk_en = 1'b0;
        rst = 1'b1;
        a8  = 8'($urandom);  b8  = 8'($urandom);  c8  = 1'b1;
        a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'b1;
        #3;
        checks++;
        if ({sub8, co8, cmp8} !== 10'd0) begin
            errors++;
            $display("FAIL reset_noclk_8: got sub=%0h carry=%0b comp=%0b, expected all 0",
                     sub8, co8, cmp8);
        end
        checks++;
        if ({sub16, co16, cmp16} !== 18'd0) begin
            errors++;
            $display("FAIL reset_noclk_16: got sub=%0h carry=%0b comp=%0b, expected all 0",
                     sub16, co16, cmp16);
        end
        // Outputs must stay cleared while edges arrive with reset held.
        clk_en = 1'b1;
        a8 = 8'd200; b8 = 8'd1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sub8, co8, cmp8} !== 10'd0) begin
            errors++;
            $display("FAIL reset_held_8: got sub=%0h carry=%0b comp=%0b, expected all 0",
                     sub8, co8, cmp8);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [7:0] ea [2] = '{8'd5, 8'd7};
        logic [7:0] ia [2] = '{8'd10, 8'd15};
        logic [7:0] ib [2] = '{8'd5, 8'd8};
        for (int i = 0; i < 2; i++) begin
            step8(ia[i], ib[i], 1'b0);
            checks++;
            if ({sub8, co8, cmp8} !== {ea[i], 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL basic_%0d: got sub=%0h carry=%0b comp=%0b, expected sub=%0h carry=0 comp=1",
                         i, sub8, co8, cmp8, ea[i]);
            end
        end
    endtask

    task automatic test_underflow;
        step8(8'd8, 8'd10, 1'b0);
        checks++;
        if ({sub8, co8, cmp8} !== {8'hFE, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL underflow: got sub=%0h carry=%0b comp=%0b, expected sub=fe carry=1 comp=0",
                     sub8, co8, cmp8);
        end
    endtask

    task automatic test_near_full;
        step8(8'hFE, 8'hFC, 1'b0);
        checks++;
        if ({sub8, co8, cmp8} !== {8'h02, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL near_full_pos: got sub=%0h carry=%0b comp=%0b, expected sub=2 carry=0 comp=1",
                     sub8, co8, cmp8);
        end
        step8(8'hFC, 8'hFE, 1'b0);
        checks++;
        if ({sub8, co8, cmp8} !== {8'hFE, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL near_full_neg: got sub=%0h carry=%0b comp=%0b, expected sub=fe carry=1 comp=0",
                     sub8, co8, cmp8);
        end
    endtask

    task automatic test_borrow_in;
        step8(8'd5, 8'd5, 1'b1);
        checks++;
        if ({sub8, co8, cmp8} !== {8'hFF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL borrow_in_eq: got sub=%0h carry=%0b comp=%0b, expected sub=ff carry=1 comp=0",
                     sub8, co8, cmp8);
        end
        // Extreme case for both widths: 0 - max - 1 wraps to 0 with a borrow.
        a16 = 16'h0000; b16 = 16'hFFFF; c16 = 1'b1;
        step8(8'h00, 8'hFF, 1'b1);
        checks++;
        if ({sub8, co8, cmp8} !== {8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL borrow_in_extreme_8: got sub=%0h carry=%0b comp=%0b, expected sub=0 carry=1 comp=0",
                     sub8, co8, cmp8);
        end
        checks++;
        if ({sub16, co16, cmp16} !== {16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL borrow_in_extreme_16: got sub=%0h carry=%0b comp=%0b, expected sub=0 carry=1 comp=0",
                     sub16, co16, cmp16);
        end
        // Borrow-in must not affect the comparison: 7 > 6 even with carry=1.
        step8(8'd7, 8'd6, 1'b1);
        checks++;
        if ({sub8, co8, cmp8} !== {8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL borrow_in_cmp: got sub=%0h carry=%0b comp=%0b, expected sub=0 carry=0 comp=1",
                     sub8, co8, cmp8);
        end
    endtask

    task automatic test_mid_reset;
        step8(8'd200, 8'd3, 1'b0);
        checks++;
        if ({sub8, co8, cmp8} !== {8'd197, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset_pre: got sub=%0h carry=%0b comp=%0b, expected sub=c5 carry=0 comp=1",
                     sub8, co8, cmp8);
        end
        // Assert reset between edges; the outputs must clear with no clock edge.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({sub8, co8, cmp8} !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset_clear: got sub=%0h carry=%0b comp=%0b, expected all 0",
                     sub8, co8, cmp8);
        end
        // The first edge after release registers the current inputs normally.
        @(negedge clk);
        rst = 1'b0;
        step8(8'd9, 8'd4, 1'b0);
        checks++;
        if ({sub8, co8, cmp8} !== {8'd5, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset_release: got sub=%0h carry=%0b comp=%0b, expected sub=5 carry=0 comp=1",
                     sub8, co8, cmp8);
        end
    endtask

    task automatic test_back_to_back;
        longint unsigned d;
        bit bo, gt;
        for (int i = 0; i < 400; i++) begin
            a8  = 8'($urandom);  b8  = 8'($urandom);  c8  = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
            // Equal operands are forced now and then so the equality edge
            // case is hit regularly.
            if (i % 17 == 0) begin
                b8 = a8; b16 = a16;
            end
            @(posedge clk);
            #1;
            model(8, 64'(a8), 64'(b8), c8, d, bo, gt);
            checks++;
            if ({sub8, co8, cmp8} !== {d[7:0], bo, gt}) begin
                errors++;
                $display("FAIL b2b_8 cyc %0d a=%0h b=%0h c=%0b: got sub=%0h carry=%0b comp=%0b, expected sub=%0h carry=%0b comp=%0b",
                         i, a8, b8, c8, sub8, co8, cmp8, d[7:0], bo, gt);
            end
            model(16, 64'(a16), 64'(b16), c16, d, bo, gt);
            checks++;
            if ({sub16, co16, cmp16} !== {d[15:0], bo, gt}) begin
                errors++;
                $display("FAIL b2b_16 cyc %0d a=%0h b=%0h c=%0b: got sub=%0h carry=%0b comp=%0b, expected sub=%0h carry=%0b comp=%0b",
                         i, a16, b16, c16, sub16, co16, cmp16, d[15:0], bo, gt);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_underflow();
        test_near_full();
        test_borrow_in();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
